// File: rtl/serial_frame_rx_pkg.sv
// ----------------------------------------------------------------------------
// serial_frame_rx_pkg
//   Shared definitions for the serial frame receiver and its transmitter-side
//   counterpart: receiver FSM state encoding and the framing bit levels.
// ----------------------------------------------------------------------------
package serial_frame_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_STOP = 2'd2
   } state_e;

   // Framing levels; the idle line rests at STOP_BIT.
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage : serial_frame_rx_pkg

// File: rtl/serial_frame_rx_shift_reg.sv
// ----------------------------------------------------------------------------
// rx_shift_reg
//   WIDTH-bit serial-in / parallel-out shift register, the receive-side mirror
//   of the transmitter's parallel-load register.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous, active-high reset (clears the register)
//   i_en    in   shift enable; one bit is taken in per enabled cycle
//   i_bit   in   serial input bit
//   o_data  out  WIDTH-bit parallel contents
//
// MSB_FIRST = 1 shifts left (new bit enters bit 0, first bit ends at the MSB);
// MSB_FIRST = 0 shifts right (new bit enters the MSB, first bit ends at bit 0).
// ----------------------------------------------------------------------------
module rx_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_bit,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_data;

   // NOTE: the register is reset even though every complete frame overwrites
   // all of it; this keeps the post-reset contents defined rather than X.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
      end else if (i_en) begin
         if (MSB_FIRST) begin
            r_data <= {r_data[WIDTH-2:0], i_bit};
         end else begin
            r_data <= {i_bit, r_data[WIDTH-1:1]};
         end
      end
   end

   assign o_data = r_data;

endmodule : rx_shift_reg

// File: rtl/serial_frame_rx.sv
// ----------------------------------------------------------------------------
// serial_frame_rx
//   Framed serial receiver. Samples s_in on s_en strobes, expects a start bit
//   (0), WIDTH data bits and a stop bit (1), and presents each good word on a
//   valid/ready parallel port. Bad stop bits pulse frame_err; words completed
//   while the previous one is still unconsumed are dropped and set overrun.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   s_in       in   serial data line (idle high)
//   s_en       in   bit strobe; s_in is sampled only when s_en = 1
//   p_out      out  received word, stable while out_valid = 1
//   out_valid  out  p_out holds an unconsumed word
//   out_ready  in   consumer accepts the word when out_valid & out_ready
//   busy       out  a frame is in progress (DATA or STOP)
//   frame_err  out  one-cycle pulse when the stop bit is sampled as 0
//   overrun    out  sticky flag, set when a completed word is dropped
// ----------------------------------------------------------------------------
module serial_frame_rx
   import serial_frame_rx_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_in,
   input  logic             s_en,
   output logic [WIDTH-1:0] p_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIDTH - 1);

   state_e           r_state;
   state_e           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_shift_en;
   logic             w_stop_ok;
   logic             w_stop_bad;
   logic             w_load;
   logic             w_drop;
   logic [WIDTH-1:0] w_shift_data;

   logic [WIDTH-1:0] r_p_out;
   logic             r_out_valid;
   logic             r_frame_err;
   logic             r_overrun;

   rx_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_shift_en),
      .i_bit  (s_in),
      .o_data (w_shift_data)
   );

   // NOTE: every signal driven here gets its default first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      w_shift_en   = 1'b0;
      w_stop_ok    = 1'b0;
      w_stop_bad   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (s_en && (s_in == START_BIT)) begin
               w_next_state = ST_DATA;
               w_cnt_next   = '0;
            end
         end
         ST_DATA: begin
            if (s_en) begin
               w_shift_en = 1'b1;
               w_cnt_next = r_cnt + 1'b1;
               // Counter stops at WIDTH: the WIDTH-th sample leaves DATA.
               if (r_cnt == LAST_IDX) begin
                  w_next_state = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (s_en) begin
               // A bad stop bit is consumed here, never reused as a start bit.
               w_next_state = ST_IDLE;
               if (s_in == STOP_BIT) begin
                  w_stop_ok = 1'b1;
               end else begin
                  w_stop_bad = 1'b1;
               end
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // A finished word may load when the slot is empty or is being emptied now.
   assign w_load = w_stop_ok & (~r_out_valid | out_ready);
   assign w_drop = w_stop_ok & ~w_load;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_p_out     <= '0;
         r_out_valid <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_cnt       <= w_cnt_next;
         r_frame_err <= w_stop_bad;
         if (w_load) begin
            r_p_out     <= w_shift_data;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_drop) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign p_out     = r_p_out;
   assign out_valid = r_out_valid;
   assign busy      = (r_state != ST_IDLE);
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule : serial_frame_rx

// File: tb/tb_serial_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_serial_frame_rx
//   Drives one serial stream into an MSB-first and an LSB-first receiver.
//   Every cycle both are compared against a frame-level reference model; the
//   directed frames additionally carry hand-derived expected values.
// ----------------------------------------------------------------------------
module tb_serial_frame_rx;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         s_in;
   logic         s_en;
   logic         out_ready;

   logic [W-1:0] p_out_m, p_out_l;
   logic         valid_m, valid_l;
   logic         busy_m, busy_l;
   logic         ferr_m, ferr_l;
   logic         ovr_m, ovr_l;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
      .clk       (clk),
      .rst       (rst),
      .s_in      (s_in),
      .s_en      (s_en),
      .p_out     (p_out_m),
      .out_valid (valid_m),
      .out_ready (out_ready),
      .busy      (busy_m),
      .frame_err (ferr_m),
      .overrun   (ovr_m)
   );

   serial_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
      .clk       (clk),
      .rst       (rst),
      .s_in      (s_in),
      .s_en      (s_en),
      .p_out     (p_out_l),
      .out_valid (valid_l),
      .out_ready (out_ready),
      .busy      (busy_l),
      .frame_err (ferr_l),
      .overrun   (ovr_l)
   );

   // ---------------- reference model (frame level) ----------------
   bit           mq[$];          // samples of the frame in progress, start bit first
   logic         m_valid = 1'b0;
   logic         m_ferr  = 1'b0;
   logic         m_ovr   = 1'b0;
   logic [W-1:0] m_word_msb = '0;
   logic [W-1:0] m_word_lsb = '0;

   task automatic model_update();
      logic old_valid;
      int   wm;
      int   wl;
      if (rst) begin
         mq.delete();
         m_valid    = 1'b0;
         m_ferr     = 1'b0;
         m_ovr      = 1'b0;
         m_word_msb = '0;
         m_word_lsb = '0;
      end else begin
         old_valid = m_valid;
         m_ferr    = 1'b0;
         if (m_valid && out_ready) m_valid = 1'b0;
         if (s_en) begin
            if (mq.size() == 0) begin
               if (s_in == 1'b0) mq.push_back(1'b0);
            end else begin
               mq.push_back(s_in);
               if (mq.size() == W + 2) begin
                  if (s_in == 1'b1) begin
                     wm = 0;
                     wl = 0;
                     for (int i = 0; i < W; i++) begin
                        wm = wm * 2 + int'(mq[1+i]);
                        wl = wl + int'(mq[1+i]) * (1 << i);
                     end
                     if (!old_valid || out_ready) begin
                        m_word_msb = W'(wm);
                        m_word_lsb = W'(wl);
                        m_valid    = 1'b1;
                     end else begin
                        m_ovr = 1'b1;
                     end
                  end else begin
                     m_ferr = 1'b1;
                  end
                  mq.delete();
               end
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic compare_model();
      logic m_busy;
      m_busy = (mq.size() != 0);
      check("model_pout_msb",  32'(p_out_m), 32'(m_word_msb));
      check("model_pout_lsb",  32'(p_out_l), 32'(m_word_lsb));
      check("model_valid_msb", 32'(valid_m), 32'(m_valid));
      check("model_valid_lsb", 32'(valid_l), 32'(m_valid));
      check("model_busy_msb",  32'(busy_m),  32'(m_busy));
      check("model_busy_lsb",  32'(busy_l),  32'(m_busy));
      check("model_ferr_msb",  32'(ferr_m),  32'(m_ferr));
      check("model_ferr_lsb",  32'(ferr_l),  32'(m_ferr));
      check("model_ovr_msb",   32'(ovr_m),   32'(m_ovr));
      check("model_ovr_lsb",   32'(ovr_l),   32'(m_ovr));
   endtask

   // One clock: DUT and model see the same inputs; outputs read 1 ns later.
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_model();
   endtask

   // Start bit, data MSB first on the wire, then the given stop bit.
   task automatic send_frame(input logic [7:0] data, input logic stop, input logic rdy);
      out_ready = rdy;
      s_en      = 1'b1;
      s_in      = 1'b0;
      step();
      for (int i = W - 1; i >= 0; i--) begin
         s_in = data[i];
         step();
      end
      s_in = stop;
      step();
   endtask

   task automatic idle_cycles(input int n);
      s_en = 1'b1;
      s_in = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       rdy;
      logic       exp_valid;
      logic [7:0] exp_msb;
      logic [7:0] exp_lsb;
      logic       exp_ferr;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      // Values seen right after the stop-bit edge of each frame.
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'hC0, 1'b1, 1'b1, 1'b1, 8'hC0, 8'h03, 1'b0, 1'b0};
      vecs[2] = '{8'h5A, 1'b0, 1'b1, 1'b0, 8'hC0, 8'h03, 1'b1, 1'b0};
      vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0};
      vecs[4] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 8'h88, 1'b0, 1'b0};
      vecs[5] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 8'h88, 1'b0, 1'b1};

      rst       = 1'b1;
      s_in      = 1'b1;
      s_en      = 1'b1;
      out_ready = 1'b1;

      // Reset, then an idle line.
      step();
      step();
      rst = 1'b0;
      idle_cycles(20);
      check("idle_valid", 32'(valid_m | valid_l), 32'd0);
      check("idle_busy",  32'(busy_m | busy_l),   32'd0);
      check("idle_pout",  32'(p_out_m | p_out_l), 32'd0);
      check("idle_flags", 32'({ferr_m, ferr_l, ovr_m, ovr_l}), 32'd0);

      // Table frames.
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].rdy);
         check($sformatf("vec%0d_valid", i), 32'({valid_m, valid_l}), 32'({2{vecs[i].exp_valid}}));
         check($sformatf("vec%0d_pmsb", i),  32'(p_out_m), 32'(vecs[i].exp_msb));
         check($sformatf("vec%0d_plsb", i),  32'(p_out_l), 32'(vecs[i].exp_lsb));
         check($sformatf("vec%0d_ferr", i),  32'({ferr_m, ferr_l}), 32'({2{vecs[i].exp_ferr}}));
         check($sformatf("vec%0d_ovr", i),   32'({ovr_m, ovr_l}),   32'({2{vecs[i].exp_ovr}}));
         check($sformatf("vec%0d_busy", i),  32'({busy_m, busy_l}), 32'd0);
         idle_cycles(1);
         // With ready high the word is gone after one cycle; frame_err is a pulse.
         if (vecs[i].rdy) check($sformatf("vec%0d_valid_1cyc", i), 32'(valid_m), 32'd0);
         check($sformatf("vec%0d_ferr_pulse", i), 32'(ferr_m), 32'd0);
         idle_cycles(1);
      end

      // Drain the held word: valid drops, overrun stays sticky.
      out_ready = 1'b1;
      s_en      = 1'b0;
      step();
      check("drain_valid", 32'({valid_m, valid_l}), 32'd0);
      check("drain_ovr",   32'({ovr_m, ovr_l}),     32'h3);
      check("drain_pout",  32'(p_out_m), 32'h11);

      // Reset in the middle of a frame.
      s_en = 1'b1;
      s_in = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         s_in = i[0];
         step();
      end
      check("midrst_busy_before", 32'(busy_m), 32'd1);
      rst  = 1'b1;
      s_en = 1'b0;
      step();
      rst = 1'b0;
      check("midrst_busy", 32'({busy_m, busy_l}), 32'd0);
      check("midrst_ovr",  32'({ovr_m, ovr_l}),   32'd0);
      send_frame(8'hF0, 1'b1, 1'b1);
      check("f0_valid", 32'({valid_m, valid_l}), 32'h3);
      check("f0_pmsb",  32'(p_out_m), 32'hF0);
      check("f0_plsb",  32'(p_out_l), 32'h0F);
      check("f0_ovr",   32'({ovr_m, ovr_l}), 32'd0);
      idle_cycles(2);

      // Random stream against the model: sparse strobes, random backpressure.
      for (int n = 0; n < 4000; n++) begin
         rst       = ($urandom_range(0, 399) == 0);
         s_en      = ($urandom_range(0, 3) != 0);
         s_in      = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      rst = 1'b0;
      idle_cycles(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_frame_rx
